// File: rtl/fetch_stage_unit.sv
// IF stage: owns the PC, drives the instruction memory address and registers the IF/ID latch.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module fetch_stage_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 MEM_SIZE = 1024,
  parameter logic [INST_W-1:0]  NOP      = 32'hE0000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [INST_W-1:0] if_id_inst,
  output logic              if_id_valid,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_flush,
  output logic [31:0]       perf_stall
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_if_id_pc4_p1;
  logic [INST_W-1:0] r_if_id_inst_p1;
  logic              r_vld_p1;

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W:0]   w_pc_end;
  logic              w_valid_f;
  logic [INST_W-1:0] w_fetched;

  // One extra bit keeps the last-byte address from wrapping near the top of the address space.
  assign w_pc_end  = {1'b0, r_pc} + (ADDR_W+1)'(3);
  assign w_valid_f = (w_pc_end < (ADDR_W+1)'(MEM_SIZE));
  assign w_fetched = w_valid_f ? imem_data : NOP;
  assign w_pc4     = r_pc + ADDR_W'(4);
  assign w_target  = branch_addr & ~(ADDR_W'(3));

  assign imem_addr = r_pc;
  assign pc        = r_pc;

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc            <= '0;
      r_if_id_pc4_p1  <= '0;
      r_if_id_inst_p1 <= NOP;
      r_vld_p1        <= 1'b0;
    end else if (branch_taken) begin
      r_pc            <= w_target;
      r_if_id_pc4_p1  <= '0;
      r_if_id_inst_p1 <= NOP;
      r_vld_p1        <= 1'b0;
    end else if (!freeze) begin
      r_pc            <= w_pc4;
      r_if_id_pc4_p1  <= w_pc4;
      r_if_id_inst_p1 <= w_fetched;
      r_vld_p1        <= w_valid_f;
    end
  end

  assign if_id_pc4   = r_if_id_pc4_p1;
  assign if_id_inst  = r_if_id_inst_p1;
  assign if_id_valid = r_vld_p1;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_stall <= '0;
    end else if (branch_taken) begin
      r_perf_flush <= sat_inc(r_perf_flush);
    end else if (freeze) begin
      r_perf_stall <= sat_inc(r_perf_stall);
    end else if (w_valid_f) begin
      r_perf_fetch <= sat_inc(r_perf_fetch);
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_flush = r_perf_flush;
  assign perf_stall = r_perf_stall;
`else
  assign perf_fetch = 32'h0;
  assign perf_flush = 32'h0;
  assign perf_stall = 32'h0;
`endif

endmodule
